// File: rtl/nes_pad_poller.sv
// Two-player NES pad poller: drives the shared latch/clock lines and shifts both pads in parallel.
// Define NES_PAD_EDGE_EN to generate the pressed/released edge-mask registers.
module nes_pad_poller #(
  parameter int CLK_DIV      = 256,
  parameter int FRAME_CYCLES = 1048576
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       poll_req,
  input  logic       data_p1,
  input  logic       data_p2,
  output logic       latch,
  output logic       nes_clk,
  output logic       busy,
  output logic       valid,
  output logic [7:0] buttons_p1,
  output logic [7:0] buttons_p2,
  output logic [7:0] pressed_p1,
  output logic [7:0] pressed_p2,
  output logic [7:0] released_p1,
  output logic [7:0] released_p2
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int FRM_W = $clog2(FRAME_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [FRM_W-1:0]  frame_q, frame_d;
  logic              pending_q, pending_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              hi_q, hi_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        sync_p1_q, sync_p1_d, sync_p2_q, sync_p2_d;
  logic [1:0][7:0]   shift_q, shift_d, buttons_q, buttons_d;
  logic              latch_q, latch_d, nes_clk_q, nes_clk_d;
  logic              busy_q, busy_d, valid_q, valid_d;
  logic              frame_wrap, div_end, start, commit_now;
  logic [1:0]        din;

  always_comb begin
    sync_p1_d  = {sync_p1_q[0], data_p1};
    sync_p2_d  = {sync_p2_q[0], data_p2};
    din        = {~sync_p2_q[1], ~sync_p1_q[1]};
    frame_wrap = (frame_q == FRM_LAST);
    frame_d    = frame_wrap ? '0 : frame_q + 1'b1;
    div_end    = (div_q == DIV_LAST);
    // A request in the same cycle that the poll launches is absorbed, never queued twice.
    start      = (state_q == IDLE) && (pending_q || poll_req);
    pending_d  = start ? 1'b0 : (pending_q | poll_req | frame_wrap);

    state_d    = state_q;
    div_d      = div_q;
    hi_d       = hi_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    buttons_d  = buttons_q;
    commit_now = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LATCH;
          div_d   = '0;
          hi_d    = 1'b0;
          bit_d   = '0;
          shift_d = '0;
        end
      end
      LATCH: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          hi_d = ~hi_q;
          if (hi_q) state_d = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_end ? '0 : div_q + 1'b1;
        if (div_end) begin
          hi_d = ~hi_q;
          if (!hi_q) begin
            for (int p = 0; p < 2; p++) shift_d[p] = {shift_q[p][6:0], din[p]};
          end else if (bit_q == 3'd7) begin
            state_d    = COMMIT;
            buttons_d  = shift_q;
            commit_now = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the pins come straight off flops.
    latch_d   = (state_d == LATCH);
    nes_clk_d = (state_d == SHIFT) && hi_d;
    busy_d    = (state_d != IDLE);
    valid_d   = commit_now;
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      frame_q   <= '0;
      pending_q <= 1'b0;
      div_q     <= '0;
      hi_q      <= 1'b0;
      bit_q     <= '0;
      sync_p1_q <= 2'b11;
      sync_p2_q <= 2'b11;
      shift_q   <= '0;
      buttons_q <= '0;
      latch_q   <= 1'b0;
      nes_clk_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      div_q     <= div_d;
      hi_q      <= hi_d;
      bit_q     <= bit_d;
      sync_p1_q <= sync_p1_d;
      sync_p2_q <= sync_p2_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      latch_q   <= latch_d;
      nes_clk_q <= nes_clk_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  assign latch      = latch_q;
  assign nes_clk    = nes_clk_q;
  assign busy       = busy_q;
  assign valid      = valid_q;
  assign buttons_p1 = buttons_q[0];
  assign buttons_p2 = buttons_q[1];

`ifdef NES_PAD_EDGE_EN
  logic [1:0][7:0] pressed_w, released_w;

  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    logic [7:0] pressed_q, pressed_d, released_q, released_d;

    always_comb begin
      pressed_d  = pressed_q;
      released_d = released_q;
      if (commit_now) begin
        pressed_d  = shift_q[gi] & ~buttons_q[gi];
        released_d = buttons_q[gi] & ~shift_q[gi];
      end
    end

    always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
        pressed_q  <= '0;
        released_q <= '0;
      end else begin
        pressed_q  <= pressed_d;
        released_q <= released_d;
      end
    end

    assign pressed_w[gi]  = pressed_q;
    assign released_w[gi] = released_q;
  end

  assign pressed_p1  = pressed_w[0];
  assign pressed_p2  = pressed_w[1];
  assign released_p1 = released_w[0];
  assign released_p2 = released_w[1];
`else
  assign pressed_p1  = '0;
  assign pressed_p2  = '0;
  assign released_p1 = '0;
  assign released_p2 = '0;
`endif

endmodule
